// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble 0,1,1,1,1,0, then PAYLOAD_BITS payload bits MSB first,
// then IDLE_GAP cycles of forced idle-high line. Payload bytes arrive over valid/ready.
module seq_frame_tx #(
   parameter int unsigned PAYLOAD_BITS = 1024,
   parameter int unsigned IDLE_GAP     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       ser_out,
   output logic       busy,
   output logic       underrun,
   output logic       frame_done
);

   localparam int unsigned SLOTS  = PAYLOAD_BITS / 8;
   localparam int unsigned SLOT_W = $clog2(SLOTS + 1);
   localparam int unsigned BIT_W  = $clog2(PAYLOAD_BITS + 1);
   localparam int unsigned GAP_W  = $clog2(IDLE_GAP + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREAMBLE,
      S_PAYLOAD,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic [7:0]        shift_q, shift_d;
   logic [SLOT_W-1:0] slots_q, slots_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [2:0]        pre_cnt_q, pre_cnt_d;
   logic              ser_d, busy_d, underrun_d, frame_done_d;

   logic              accept_c;
   logic              boundary_c;
   logic              pad_c;
   logic [7:0]        load_byte_c;
   logic [SLOT_W:0]   slot_sum_c;

   assign data_ready = !hold_full_q && (state_q != S_GAP) && (slots_q < SLOT_W'(SLOTS));
   assign accept_c   = data_valid && data_ready;

   // A byte boundary is the preamble exit (byte 0) or every 8th payload bit before the end
   assign boundary_c = ((state_q == S_PREAMBLE) && (pre_cnt_q == 3'd5)) ||
                       ((state_q == S_PAYLOAD) && (bit_cnt_q != BIT_W'(PAYLOAD_BITS)) &&
                        (bit_cnt_q[2:0] == 3'd0));
   assign pad_c       = boundary_c && !hold_full_q;
   assign load_byte_c = hold_full_q ? hold_q : 8'h00;

   // Padded slots and accepted bytes both consume a slot; saturate at the frame size
   assign slot_sum_c = {1'b0, slots_q} + (SLOT_W + 1)'(accept_c) + (SLOT_W + 1)'(pad_c);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         shift_q     <= 8'h00;
         slots_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         pre_cnt_q   <= 3'd0;
         ser_out     <= 1'b1;
         busy        <= 1'b0;
         underrun    <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         slots_q     <= slots_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         pre_cnt_q   <= pre_cnt_d;
         ser_out     <= ser_d;
         busy        <= busy_d;
         underrun    <= underrun_d;
         frame_done  <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      pre_cnt_d    = pre_cnt_q;
      ser_d        = ser_out;
      busy_d       = busy;
      underrun_d   = 1'b0;
      frame_done_d = 1'b0;
      slots_d      = (slot_sum_c > (SLOT_W + 1)'(SLOTS)) ? SLOT_W'(SLOTS) : slot_sum_c[SLOT_W-1:0];

      // A reload consumes the old hold contents; a byte accepted on the same edge refills it
      if (boundary_c) hold_full_d = 1'b0;
      if (accept_c) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            ser_d  = 1'b1;
            busy_d = 1'b0;
            if (accept_c || hold_full_q) begin
               state_d   = S_PREAMBLE;
               pre_cnt_d = 3'd0;
               ser_d     = 1'b0;
               busy_d    = 1'b1;
            end
         end
         S_PREAMBLE: begin
            if (pre_cnt_q == 3'd5) begin
               state_d    = S_PAYLOAD;
               ser_d      = load_byte_c[7];
               shift_d    = {load_byte_c[6:0], 1'b0};
               bit_cnt_d  = BIT_W'(1);
               underrun_d = pad_c;
            end else begin
               pre_cnt_d = pre_cnt_q + 3'd1;
               ser_d     = (pre_cnt_q + 3'd1) != 3'd5;
            end
         end
         S_PAYLOAD: begin
            if (bit_cnt_q == BIT_W'(PAYLOAD_BITS)) begin
               state_d      = S_GAP;
               ser_d        = 1'b1;
               frame_done_d = 1'b1;
               gap_cnt_d    = GAP_W'(1);
            end else if (boundary_c) begin
               ser_d      = load_byte_c[7];
               shift_d    = {load_byte_c[6:0], 1'b0};
               bit_cnt_d  = bit_cnt_q + BIT_W'(1);
               underrun_d = pad_c;
            end else begin
               ser_d     = shift_q[7];
               shift_d   = {shift_q[6:0], 1'b0};
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end
         S_GAP: begin
            ser_d = 1'b1;
            if (gap_cnt_q == GAP_W'(IDLE_GAP)) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               slots_d   = SLOT_W'(hold_full_q);
               bit_cnt_d = '0;
               gap_cnt_d = '0;
               pre_cnt_d = 3'd0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx with a 24-bit payload and a 2-cycle gap.
module tb_seq_frame_tx;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic       ser_out;
   logic       busy;
   logic       underrun;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   seq_frame_tx #(.PAYLOAD_BITS(24), .IDLE_GAP(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .ser_out    (ser_out),
      .busy       (busy),
      .underrun   (underrun),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one frame from IDLE; c counts edges after the edge that accepts byte 0.
   task automatic run_frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int nb,
                            input int rel1, input logic [23:0] exp_bits, input int exp_und,
                            input int exp_acc, input logic chk_rdy);
      logic [7:0]  bytes [4];
      logic [29:0] stream;
      logic        pre;
      logic        fourth;
      int          idx;
      int          acc;
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
      stream = {6'b011110, exp_bits};
      fourth = (nb == 4);
      data_in    = bytes[0];
      data_valid = 1'b1;
      chk({name, " idle_ready"}, 32'(data_ready), 32'd1);
      step();
      idx = 1;
      acc = 1;
      for (int c = 0; c <= 33; c++) begin
         if (c < 30) chk($sformatf("%s ser c%0d", name, c), 32'(ser_out), 32'(stream[29-c]));
         else if (c < 33) chk($sformatf("%s ser c%0d", name, c), 32'(ser_out), 32'd1);
         else chk($sformatf("%s ser c%0d", name, c), 32'(ser_out), 32'(!fourth));
         chk($sformatf("%s busy c%0d", name, c), 32'(busy), 32'((c < 32) || (c == 33 && fourth)));
         chk($sformatf("%s done c%0d", name, c), 32'(frame_done), 32'(c == 30));
         chk($sformatf("%s und c%0d", name, c), 32'(underrun), 32'(c == exp_und));
         if (chk_rdy)
            chk($sformatf("%s rdy c%0d", name, c), 32'(data_ready),
                32'(c == 6 || c == 14 || c == 32));
         if (c == 33) break;
         if (idx < nb) begin
            data_valid = (idx != 1) || (c >= rel1);
            data_in    = bytes[idx];
         end else begin
            data_valid = 1'b0;
         end
         pre = data_valid && data_ready;
         step();
         if (pre) begin
            idx++;
            if (c + 1 <= 32) acc++;
         end
      end
      data_valid = 1'b0;
      chk({name, " accepts"}, 32'(acc), 32'(exp_acc));
   endtask

   initial begin
      rst        = 1'b0;
      data_in    = 8'h5A;
      data_valid = 1'b0;

      // Reset held with valid toggling: line idle, ready, no pulses
      for (int i = 0; i < 4; i++) begin
         data_valid = ~data_valid;
         step();
         chk($sformatf("rst ser %0d", i), 32'(ser_out), 32'd1);
         chk($sformatf("rst rdy %0d", i), 32'(data_ready), 32'd1);
         chk($sformatf("rst busy %0d", i), 32'(busy), 32'd0);
         chk($sformatf("rst pulses %0d", i), 32'({underrun, frame_done}), 32'd0);
      end
      data_valid = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post_rst ser %0d", i), 32'(ser_out), 32'd1);
         chk($sformatf("post_rst busy %0d", i), 32'(busy), 32'd0);
      end

      // Full-rate frame
      run_frame("full", 8'hA5, 8'h3C, 8'h5A, 8'h00, 3, 0, 24'hA53C5A, -1, 3, 1'b0);

      // Second byte withheld past its reload edge: slot padded, late byte fills the next slot
      run_frame("undr", 8'hFF, 8'h81, 8'h00, 8'h00, 2, 15, 24'hFF0081, 14, 2, 1'b0);

      // Valid held high with four bytes: three fit, the fourth starts the next frame
      run_frame("bp", 8'h11, 8'h22, 8'h33, 8'h44, 4, 0, 24'h112233, -1, 3, 1'b1);

      // Frame carrying 0x44 is in flight; stop at payload bit j=2 (a 0) and reset asynchronously
      for (int i = 0; i < 8; i++) step();
      chk("mid ser_before", 32'(ser_out), 32'd0);
      chk("mid busy_before", 32'(busy), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid ser_async", 32'(ser_out), 32'd1);
      chk("mid busy_async", 32'(busy), 32'd0);
      chk("mid rdy_async", 32'(data_ready), 32'd1);
      step();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("mid idle ser %0d", i), 32'(ser_out), 32'd1);
         chk($sformatf("mid idle busy %0d", i), 32'(busy), 32'd0);
      end

      // New frame after reset starts with a complete preamble
      run_frame("again", 8'h96, 8'h0F, 8'hF0, 8'h00, 3, 0, 24'h960FF0, -1, 3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
